// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN datapath blocks (tap layout, saturation, sizing).
`define CNN_TAP_UNPACK(bus, i, w) bus[(i)*(w) +: (w)]

package cnn_pkg;
  localparam int CNN_DATA_BW = 8;
  localparam int CNN_ACC_BW  = 24;

  // Per-beat side information that travels down the pipeline next to the data.
  typedef struct packed {
    logic       last;
    logic       first;
    logic [4:0] shift;
    logic       relu;
  } beat_ctl_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction
endpackage

// File: rtl/booth_multiplier.sv
// Combinational radix-2 Booth signed multiplier, full 2*W-bit product.
module booth_multiplier #(
  parameter int W = 8
) (
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] p
);
  logic [W:0]            b_ext;
  logic signed [2*W-1:0] a_ext;

  assign b_ext = {b, 1'b0};
  assign a_ext = (2*W)'(a);

  // Each {b[i], b[i-1]} pair adds, subtracts or skips a shifted copy of a.
  always_comb begin
    p = '0;
    for (int i = 0; i < W; i++) begin
      case (b_ext[i +: 2])
        2'b01:   p = p + (a_ext <<< i);
        2'b10:   p = p - (a_ext <<< i);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/mac_dot_n.sv
// N-tap signed dot product: registered products (S2) then a registered adder-tree sum (S3).
module mac_dot_n import cnn_pkg::*; #(
  parameter int N       = 25,
  parameter int DATA_BW = CNN_DATA_BW,
  parameter int ACC_BW  = CNN_ACC_BW
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     en,
  input  logic [N*DATA_BW-1:0]     ifmap,
  input  logic [N*DATA_BW-1:0]     filter,
  output logic signed [ACC_BW-1:0] sum_q
);
  localparam int PW = 2 * DATA_BW;
  localparam int NP = 1 << clog2(N);

  logic signed [PW-1:0]     prod_d [N];
  logic signed [PW-1:0]     prod_q [N];
  logic signed [ACC_BW-1:0] sum_d;

  for (genvar i = 0; i < N; i++) begin : g_mul
    booth_multiplier #(.W(DATA_BW)) u_mul (
      .a($signed(`CNN_TAP_UNPACK(ifmap, i, DATA_BW))),
      .b($signed(`CNN_TAP_UNPACK(filter, i, DATA_BW))),
      .p(prod_d[i])
    );
  end

  // Binary tree padded to a power of two; leaves are sign-extended products.
  function automatic logic signed [ACC_BW-1:0] tree_sum(input logic signed [PW-1:0] p [N]);
    logic signed [ACC_BW-1:0] node [1:2*NP-1];
    for (int j = 1; j < 2 * NP; j++) node[j] = '0;
    for (int i = 0; i < N; i++) node[NP+i] = ACC_BW'(p[i]);
    for (int j = NP - 1; j >= 1; j--) node[j] = node[2*j] + node[2*j+1];
    return node[1];
  endfunction

  assign sum_d = tree_sum(prod_q);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      prod_q <= '{default: '0};
      sum_q  <= '0;
    end else if (en) begin
      prod_q <= prod_d;
      sum_q  <= sum_d;
    end
  end
endmodule

// File: rtl/conv_mac_pe.sv
// KxK convolution PE: per-channel window dot products accumulated over a group, plus bias,
// shift, optional ReLU and saturation. Handshake: a beat transfers on an edge where
// IN_VALID && IN_READY, a result on OUT_VALID && OUT_READY; the whole pipe advances only
// when the output slot is empty or being drained, so IN_READY equals that advance enable.
module conv_mac_pe import cnn_pkg::*; #(
  parameter int DATA_BW = CNN_DATA_BW,
  parameter int KSIZE   = 5,
  parameter int ACC_BW  = CNN_ACC_BW,
  parameter int OUT_BW  = 16
) (
  input  logic                           CLK,
  input  logic                           RSTN,
  input  logic                           CLR,
  input  logic                           IN_VALID,
  output logic                           IN_READY,
  input  logic                           IN_LAST,
  input  logic [KSIZE*KSIZE*DATA_BW-1:0] IFMAP,
  input  logic [KSIZE*KSIZE*DATA_BW-1:0] FILTER,
  input  logic [ACC_BW-1:0]              BIAS,
  input  logic [4:0]                     SHIFT,
  input  logic                           RELU_EN,
  output logic                           OUT_VALID,
  input  logic                           OUT_READY,
  output logic [OUT_BW-1:0]              OUT_DATA
);
  localparam int N = KSIZE * KSIZE;

  logic                     pipe_en;
  logic                     first_q, first_d;
  logic                     s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
  beat_ctl_t                s1_ctl_q, s1_ctl_d, s2_ctl_q, s2_ctl_d, s3_ctl_q, s3_ctl_d;
  logic signed [ACC_BW-1:0] s1_bias_q, s1_bias_d, s2_bias_q, s2_bias_d, s3_bias_q, s3_bias_d;
  logic [N*DATA_BW-1:0]     ifmap_q, ifmap_d, filter_q, filter_d;
  logic signed [ACC_BW-1:0] sum_q, acc_q, acc_d, acc_next, shifted;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_BW-1:0]        out_data_q, out_data_d;

  assign pipe_en   = !out_valid_q || OUT_READY;
  assign IN_READY  = pipe_en;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;

  mac_dot_n #(.N(N), .DATA_BW(DATA_BW), .ACC_BW(ACC_BW)) u_dot (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .en     (pipe_en),
    .ifmap  (ifmap_q),
    .filter (filter_q),
    .sum_q  (sum_q)
  );

  // The shift is applied before ReLU and saturation, on the wrapped accumulator value.
  always_comb begin
    acc_next = s3_ctl_q.first ? sum_q + s3_bias_q : acc_q + sum_q;
    shifted  = acc_next >>> s3_ctl_q.shift;
    if (s3_ctl_q.relu && shifted < 0) shifted = '0;
  end

  always_comb begin
    first_d     = first_q;
    s1_valid_d  = s1_valid_q;  s1_ctl_d = s1_ctl_q;  s1_bias_d = s1_bias_q;
    s2_valid_d  = s2_valid_q;  s2_ctl_d = s2_ctl_q;  s2_bias_d = s2_bias_q;
    s3_valid_d  = s3_valid_q;  s3_ctl_d = s3_ctl_q;  s3_bias_d = s3_bias_q;
    ifmap_d     = ifmap_q;
    filter_d    = filter_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (pipe_en) begin
      s1_valid_d = IN_VALID;
      if (IN_VALID) begin
        s1_ctl_d  = '{last: IN_LAST, first: first_q, shift: SHIFT, relu: RELU_EN};
        s1_bias_d = $signed(BIAS);
        ifmap_d   = IFMAP;
        filter_d  = FILTER;
        first_d   = IN_LAST;
      end
      s2_valid_d  = s1_valid_q;  s2_ctl_d = s1_ctl_q;  s2_bias_d = s1_bias_q;
      s3_valid_d  = s2_valid_q;  s3_ctl_d = s2_ctl_q;  s3_bias_d = s2_bias_q;
      out_valid_d = 1'b0;
      if (s3_valid_q) begin
        acc_d = acc_next;
        if (s3_ctl_q.last) begin
          out_valid_d = 1'b1;
          out_data_d  = OUT_BW'(sat_signed(64'(shifted), OUT_BW));
        end
      end
    end
    // A flush wins over any beat arriving in the same cycle.
    if (CLR) begin
      first_d     = 1'b1;
      s1_valid_d  = 1'b0;
      s2_valid_d  = 1'b0;
      s3_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      acc_d       = '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      first_q     <= 1'b1;
      s1_valid_q  <= 1'b0;  s1_ctl_q <= '0;  s1_bias_q <= '0;
      s2_valid_q  <= 1'b0;  s2_ctl_q <= '0;  s2_bias_q <= '0;
      s3_valid_q  <= 1'b0;  s3_ctl_q <= '0;  s3_bias_q <= '0;
      ifmap_q     <= '0;
      filter_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      first_q     <= first_d;
      s1_valid_q  <= s1_valid_d;  s1_ctl_q <= s1_ctl_d;  s1_bias_q <= s1_bias_d;
      s2_valid_q  <= s2_valid_d;  s2_ctl_q <= s2_ctl_d;  s2_bias_q <= s2_bias_d;
      s3_valid_q  <= s3_valid_d;  s3_ctl_q <= s3_ctl_d;  s3_bias_q <= s3_bias_d;
      ifmap_q     <= ifmap_d;
      filter_q    <= filter_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

// File: tb/tb_conv_mac_pe.sv
// Directed bench for conv_mac_pe at KSIZE=5, OUT_BW=16; hand-computed results in an ordered queue.
module tb_conv_mac_pe;
  localparam int DATA_BW = 8;
  localparam int KSIZE   = 5;
  localparam int N       = KSIZE * KSIZE;
  localparam int ACC_BW  = 24;
  localparam int OUT_BW  = 16;
  localparam int BUS_W   = N * DATA_BW;

  logic              CLK = 1'b0;
  logic              RSTN = 1'b0;
  logic              CLR = 1'b0;
  logic              IN_VALID = 1'b0;
  logic              IN_READY;
  logic              IN_LAST = 1'b0;
  logic [BUS_W-1:0]  IFMAP = '0;
  logic [BUS_W-1:0]  FILTER = '0;
  logic [ACC_BW-1:0] BIAS = '0;
  logic [4:0]        SHIFT = '0;
  logic              RELU_EN = 1'b0;
  logic              OUT_VALID;
  logic              OUT_READY = 1'b1;
  logic [OUT_BW-1:0] OUT_DATA;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pushed = 0;
  int n_out    = 0;
  logic [OUT_BW-1:0] exp_q[$];
  logic              held = 1'b0;
  logic [OUT_BW-1:0] held_data = '0;

  conv_mac_pe #(
    .DATA_BW(DATA_BW), .KSIZE(KSIZE), .ACC_BW(ACC_BW), .OUT_BW(OUT_BW)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .CLR(CLR),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_LAST(IN_LAST),
    .IFMAP(IFMAP), .FILTER(FILTER), .BIAS(BIAS), .SHIFT(SHIFT), .RELU_EN(RELU_EN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA)
  );

  // Clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic logic [BUS_W-1:0] fill(input int v);
    logic [BUS_W-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) b[i*DATA_BW +: DATA_BW] = DATA_BW'(v);
    return b;
  endfunction

  function automatic logic [BUS_W-1:0] one_tap(input int v);
    logic [BUS_W-1:0] b;
    b = '0;
    b[DATA_BW-1:0] = DATA_BW'(v);
    return b;
  endfunction

  task automatic push_exp(input int v);
    exp_q.push_back(OUT_BW'(v));
    n_pushed++;
  endtask

  // Driver: holds the beat until an edge where IN_READY was high.
  task automatic send_beat(input logic [BUS_W-1:0] ifm, input logic [BUS_W-1:0] flt,
                           input int bias, input logic last, input int shift, input logic relu);
    logic accepted;
    int   waited;
    IFMAP = ifm; FILTER = flt; BIAS = ACC_BW'(bias); IN_LAST = last;
    SHIFT = 5'(shift); RELU_EN = relu; IN_VALID = 1'b1;
    accepted = 1'b0;
    waited   = 0;
    while (!accepted && waited < 200) begin
      @(negedge CLK);
      accepted = IN_READY;
      @(posedge CLK);
      #1;
      waited++;
    end
    IN_VALID = 1'b0;
    if (!accepted) check("accept_in_time", accepted, 1);
  endtask

  task automatic clr_pulse();
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge CLK);
      #1;
      w++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Scoreboard: every output transfer pops one expected value; stalled outputs must hold.
  always @(negedge CLK) begin
    if (!RSTN) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", OUT_VALID, 1);
        check("hold_data", OUT_DATA, held_data);
      end
      held      = OUT_VALID && !OUT_READY;
      held_data = OUT_DATA;
      if (OUT_VALID && OUT_READY) begin
        n_out++;
        if (exp_q.size() == 0) check("spurious_out", n_out, n_pushed);
        else check("out_data", OUT_DATA, exp_q.pop_front());
      end
    end
  end

  initial begin
    int edges;
    int base;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_out_data", OUT_DATA, 0);
    check("rst_in_ready", IN_READY, 1);
    RSTN = 1'b1;
    @(posedge CLK);
    #1;

    // Single channel: 25 * (2*3) + 10 = 160; the accepting edge counts as edge 1.
    push_exp(160);
    send_beat(fill(2), fill(3), 10, 1'b1, 0, 1'b0);
    edges = 1;
    while (!OUT_VALID && edges < 20) begin
      @(posedge CLK);
      #1;
      edges++;
    end
    check("latency_edges", edges, 4);
    wait_drain();

    // Three channels 100, -40, 25 with bias -5 from the first beat only -> 80.
    base = n_out;
    push_exp(80);
    send_beat(one_tap(10), one_tap(10), -5, 1'b0, 0, 1'b0);
    send_beat(one_tap(-8), one_tap(5), 1000, 1'b0, 0, 1'b0);
    send_beat(one_tap(5), one_tap(5), 1000, 1'b1, 0, 1'b0);
    wait_drain();
    repeat (6) @(posedge CLK);
    #1;
    check("group_pulses", n_out - base, 1);

    // Saturation, ReLU and shift corners, issued back to back.
    push_exp(32767);  send_beat(fill(-128), fill(-128), 0, 1'b1, 0, 1'b0);
    push_exp(-32768); send_beat(fill(-128), fill(127), 0, 1'b1, 0, 1'b0);
    push_exp(25600);  send_beat(fill(-128), fill(-128), 0, 1'b1, 4, 1'b0);
    push_exp(0);      send_beat(fill(-1), fill(2), 0, 1'b1, 0, 1'b1);
    push_exp(-50);    send_beat(fill(-1), fill(2), 0, 1'b1, 0, 1'b0);
    push_exp(160);    send_beat(fill(2), fill(3), 10, 1'b1, 0, 1'b1);
    push_exp(10);     send_beat(fill(2), fill(3), 10, 1'b1, 4, 1'b0);
    push_exp(-13);    send_beat(fill(-1), fill(2), 0, 1'b1, 2, 1'b0);
    wait_drain();

    // Backpressure during back-to-back groups.
    OUT_READY = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          push_exp(3 * k);
          send_beat(one_tap(k), one_tap(3), 0, 1'b1, 0, 1'b0);
        end
        push_exp(30);
        send_beat(one_tap(5), one_tap(5), 1, 1'b0, 0, 1'b0);
        send_beat(one_tap(2), one_tap(2), 7, 1'b1, 0, 1'b0);
      end
      begin
        int w;
        w = 0;
        while (!OUT_VALID && w < 50) begin
          @(posedge CLK);
          #1;
          w++;
        end
        check("stall_fill", OUT_VALID, 1);
        repeat (5) begin
          @(negedge CLK);
          check("stall_in_ready", IN_READY, 0);
        end
        @(posedge CLK);
        #1;
        OUT_READY = 1'b1;
      end
    join
    wait_drain();

    // CLR drops a partial group, and also a beat presented alongside it.
    send_beat(fill(7), fill(7), 500, 1'b0, 0, 1'b0);
    send_beat(fill(7), fill(7), 500, 1'b0, 0, 1'b0);
    repeat (4) @(posedge CLK);
    #1;
    clr_pulse();
    CLR = 1'b1;
    send_beat(fill(1), fill(1), 0, 1'b1, 0, 1'b0);
    CLR = 1'b0;
    push_exp(7);
    send_beat(one_tap(7), one_tap(1), 0, 1'b1, 0, 1'b0);
    wait_drain();

    // Asynchronous reset mid-group, away from any clock edge.
    send_beat(fill(3), fill(3), 9, 1'b0, 0, 1'b0);
    send_beat(fill(3), fill(3), 9, 1'b0, 0, 1'b0);
    repeat (4) @(posedge CLK);
    #2;
    RSTN = 1'b0;
    #1;
    check("async_rst_out_valid", OUT_VALID, 0);
    check("async_rst_out_data", OUT_DATA, 0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    @(posedge CLK);
    #1;
    push_exp(28);
    send_beat(fill(1), fill(1), 3, 1'b1, 0, 1'b0);
    wait_drain();

    repeat (8) @(posedge CLK);
    #1;
    check("out_count", n_out, n_pushed);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
